// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot ROM shadow-copy engine.
package boot_loader_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LATCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Also used by the top-level address decoder to place the RAM shadow.
  localparam logic [15:0] RAM_BASE_DEFAULT = 16'hE000;

endpackage

// File: rtl/boot_loader.sv
// Copies the whole boot ROM into RAM at RAM_BASE while holding the CPU in reset;
// one byte per FETCH/LATCH/WRITE pass, with RAM back-pressure honoured in WRITE.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int                    ROM_ADDR_W = 13,
  parameter int                    RAM_ADDR_W = 16,
  parameter logic [RAM_ADDR_W-1:0] RAM_BASE   = RAM_ADDR_W'(RAM_BASE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_we,
  input  logic                  ram_ready,
  output logic                  cpu_rst,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [ROM_ADDR_W-1:0] index_q, index_d;
  logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;

  logic accept;
  logic last;

  assign accept = ram_we_q & ram_ready;
  // Last byte is recognised by the all-ones index, never by counter wrap.
  assign last   = &index_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      index_q     <= '0;
      rom_addr_q  <= '0;
      ram_addr_q  <= RAM_BASE;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      rom_addr_q  <= rom_addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   state_d = LATCH;
      LATCH:   state_d = WRITE;
      WRITE:   if (accept) state_d = last ? DONE : FETCH;
      DONE:    if (restart) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    index_d     = index_q;
    rom_addr_d  = rom_addr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = ram_we_q;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    unique case (state_q)
      LATCH: begin
        // ROM output is valid now, one cycle after it sampled rom_addr.
        ram_wdata_d = rom_data;
        ram_addr_d  = RAM_BASE + RAM_ADDR_W'(index_q);
        ram_we_d    = 1'b1;
      end
      WRITE: begin
        if (accept) begin
          ram_we_d = 1'b0;
          if (last) begin
            cpu_rst_d  = 1'b0;
            done_d     = 1'b1;
            rom_addr_d = '0;
          end else begin
            index_d    = index_q + ROM_ADDR_W'(1);
            rom_addr_d = index_q + ROM_ADDR_W'(1);
          end
        end
      end
      DONE: begin
        if (restart) begin
          index_d   = '0;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign rom_addr  = rom_addr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: 16-byte ROM model, RAM model and a write scoreboard.
module tb_boot_loader;

  localparam int AW = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, restart, ram_ready;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [15:0]   ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we, cpu_rst, done;

  logic          rst_w, restart_w, ready_w;
  logic [AW-1:0] rom_addr_w;
  logic [7:0]    rom_data_w;
  logic [15:0]   ram_addr_w;
  logic [7:0]    ram_wdata_w;
  logic          ram_we_w, cpu_rst_w, done_w;

  boot_loader #(.ROM_ADDR_W(AW), .RAM_ADDR_W(16), .RAM_BASE(16'hE000)) dut (
    .clk(clk), .rst(rst), .restart(restart), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_ready(ram_ready),
    .cpu_rst(cpu_rst), .done(done));

  boot_loader #(.ROM_ADDR_W(AW), .RAM_ADDR_W(16), .RAM_BASE(16'hFFF8)) dut_w (
    .clk(clk), .rst(rst_w), .restart(restart_w), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
    .ram_addr(ram_addr_w), .ram_wdata(ram_wdata_w), .ram_we(ram_we_w), .ram_ready(ready_w),
    .cpu_rst(cpu_rst_w), .done(done_w));

  function automatic logic [7:0] rom_byte(input int i);
    return 8'(i) ^ 8'hA5;
  endfunction

  // Boot ROM: registered address, data one cycle later.
  always @(posedge clk) begin
    rom_data   <= rom_byte(int'(rom_addr));
    rom_data_w <= rom_byte(int'(rom_addr_w));
  end

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        exp_q[$], act_q[$], expw_q[$], actw_q[$];
  logic [7:0] ram_mem [0:65535];
  int         errors = 0;
  int         checks = 0;
  int         we_done_viol = 0;
  int         range_viol = 0;

  // RAM model and write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t w;
    if (ram_we === 1'b1 && ram_ready === 1'b1) begin
      w.a = ram_addr; w.d = ram_wdata;
      act_q.push_back(w);
      ram_mem[ram_addr] = ram_wdata;
    end
    if (ram_we === 1'b1 && done === 1'b1) we_done_viol++;
    if (ram_we_w === 1'b1 && ready_w === 1'b1) begin
      w.a = ram_addr_w; w.d = ram_wdata_w;
      actw_q.push_back(w);
      if (!(ram_addr_w >= 16'hFFF8 || ram_addr_w <= 16'h0007)) range_viol++;
    end
    if (ram_we_w === 1'b1 && done_w === 1'b1) we_done_viol++;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push_copy(input logic [15:0] base, input int count, input bit wrap);
    wr_t w;
    for (int i = 0; i < count; i++) begin
      w.a = base + 16'(i);
      w.d = rom_byte(i);
      if (wrap) expw_q.push_back(w);
      else      exp_q.push_back(w);
    end
  endtask

  task automatic check_sb(input string name, input bit wrap);
    wr_t eq[$], aq[$];
    wr_t e, a;
    if (wrap) begin
      eq = expw_q; aq = actw_q; expw_q.delete(); actw_q.delete();
    end else begin
      eq = exp_q; aq = act_q; exp_q.delete(); act_q.delete();
    end
    while (eq.size() > 0) begin
      e = eq.pop_front();
      checks++;
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL %s write: got none, expected addr=%h data=%h", name, e.a, e.d);
      end else begin
        a = aq.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL %s write: got addr=%h data=%h, expected addr=%h data=%h",
                   name, a.a, a.d, e.a, e.d);
        end
      end
    end
    checks++;
    if (aq.size() != 0) begin
      errors++;
      $display("FAIL %s extra_writes: got %0d, expected 0", name, aq.size());
    end
  endtask

  // Runs the main DUT until done, optionally stalling one byte or pulsing restart.
  task automatic run_copy(input string name, input int stall_byte, input int stall_len,
                          input int restart_at, output int cycles);
    bit stalled = 1'b0;
    cycles = 0;
    while (cycles < 300) begin
      tick;
      cycles++;
      restart = 1'b0;
      if (done === 1'b1) break;
      if (cycles == restart_at) restart = 1'b1;
      if (!stalled && stall_byte >= 0 && ram_we === 1'b1 &&
          ram_addr == 16'hE000 + 16'(stall_byte)) begin
        stalled   = 1'b1;
        ram_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick;
          cycles++;
          checks++;
          if (ram_we !== 1'b1 || ram_addr !== 16'hE000 + 16'(stall_byte) ||
              ram_wdata !== rom_byte(stall_byte) || rom_addr !== AW'(stall_byte)) begin
            errors++;
            $display("FAIL %s stall_hold: got we=%b addr=%h data=%h rom_addr=%h, expected we=1 addr=%h data=%h rom_addr=%h",
                     name, ram_we, ram_addr, ram_wdata, rom_addr,
                     16'hE000 + 16'(stall_byte), rom_byte(stall_byte), AW'(stall_byte));
          end
        end
        ram_ready = 1'b1;
      end
    end
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, expected 1", name, done, cycles);
    end
  endtask

  task automatic check_done(input string name, input int cycles, input int exp_cycles);
    checks++;
    if (cycles !== exp_cycles) begin
      errors++;
      $display("FAIL %s latency: got %0d, expected %0d", name, cycles, exp_cycles);
    end
    checks++;
    if (cpu_rst !== 1'b0 || done !== 1'b1 || rom_addr !== '0) begin
      errors++;
      $display("FAIL %s done_state: got cpu_rst=%b done=%b rom_addr=%h, expected 0 1 0",
               name, cpu_rst, done, rom_addr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; restart = 1'b0; ram_ready = 1'b1;
    rst_w = 1'b1; restart_w = 1'b0; ready_w = 1'b1;
    tick;
    tick;
    checks++;
    if (rom_addr !== '0 || ram_addr !== 16'hE000 || ram_wdata !== 8'h00 ||
        ram_we !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got rom_addr=%h ram_addr=%h wdata=%h we=%b cpu_rst=%b done=%b, expected 0 e000 00 0 1 0",
               rom_addr, ram_addr, ram_wdata, ram_we, cpu_rst, done);
    end
  endtask

  task automatic test_basic_copy;
    int c;
    push_copy(16'hE000, N, 1'b0);
    rst = 1'b0;
    run_copy("basic", -1, 0, -1, c);
    check_done("basic", c, 3 * N);
    check_sb("basic", 1'b0);
  endtask

  task automatic test_stall;
    int c;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    push_copy(16'hE000, N, 1'b0);
    run_copy("stall", 7, 5, -1, c);
    check_done("stall", c, 3 * N + 5);
    check_sb("stall", 1'b0);
  endtask

  task automatic test_rst_mid_write;
    int c;
    int n;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    push_copy(16'hE000, 9, 1'b0);
    n = 0;
    while (n < 100 && !(ram_we === 1'b1 && ram_addr == 16'hE009)) begin
      tick;
      n++;
    end
    ram_ready = 1'b0;
    rst = 1'b1;
    tick;
    checks++;
    if (ram_we !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0 || ram_addr !== 16'hE000) begin
      errors++;
      $display("FAIL rst_mid_write: got we=%b cpu_rst=%b done=%b addr=%h, expected 0 1 0 e000",
               ram_we, cpu_rst, done, ram_addr);
    end
    rst = 1'b0;
    ram_ready = 1'b1;
    push_copy(16'hE000, N, 1'b0);
    run_copy("rst_restart", -1, 0, -1, c);
    check_done("rst_restart", c, 3 * N);
    check_sb("rst_restart", 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ram_mem[16'hE000 + 16'(i)] !== rom_byte(i)) begin
        errors++;
        $display("FAIL ram_image[%0d]: got %h, expected %h", i, ram_mem[16'hE000 + 16'(i)], rom_byte(i));
      end
    end
  endtask

  task automatic test_restart;
    int c;
    restart = 1'b1;
    tick;
    restart = 1'b0;
    checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: got cpu_rst=%b done=%b, expected 1 0", cpu_rst, done);
    end
    push_copy(16'hE000, N, 1'b0);
    run_copy("restart", -1, 0, 10, c);
    check_done("restart", c, 3 * N);
    check_sb("restart", 1'b0);
  endtask

  task automatic test_wrap;
    int c;
    push_copy(16'hFFF8, N, 1'b1);
    rst_w = 1'b0;
    c = 0;
    while (c < 300 && done_w !== 1'b1) begin
      tick;
      c++;
    end
    checks++;
    if (c !== 3 * N || cpu_rst_w !== 1'b0) begin
      errors++;
      $display("FAIL wrap_latency: got %0d cpu_rst=%b, expected %0d 0", c, cpu_rst_w, 3 * N);
    end
    check_sb("wrap", 1'b1);
    checks++;
    if (range_viol !== 0) begin
      errors++;
      $display("FAIL wrap_range: got %0d out-of-window writes, expected 0", range_viol);
    end
  endtask

  task automatic test_we_while_done;
    repeat (4) tick;
    checks++;
    if (we_done_viol !== 0) begin
      errors++;
      $display("FAIL we_while_done: got %0d, expected 0", we_done_viol);
    end
  endtask

  initial begin
    test_reset;
    test_basic_copy;
    test_stall;
    test_rst_mid_write;
    test_restart;
    test_wrap;
    test_we_while_done;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
